// File: rtl/trig_record_readout.sv
// trig_record_readout: circular FIFO of trigger records (8-bit mask + 56-bit
// timestamp) with a host-requested, checksummed 10-byte frame readout over a
// valid/ready byte stream. Includes occupancy, saturating overflow count and
// a synchronous flush.
module trig_record_readout #(
   parameter int DEPTH = 8,
   parameter int TS_W  = 56
) (
   input  logic            clk_adc,
   input  logic            rst,
   input  logic            rec_valid,
   input  logic [7:0]      rec_bits,
   input  logic [TS_W-1:0] rec_time,
   input  logic            flush,
   input  logic            read_req,
   output logic [7:0]      tx_data,
   output logic            tx_valid,
   input  logic            tx_ready,
   output logic [4:0]      fill_level,
   output logic [15:0]     overflow_count,
   output logic            busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_BITS, S_TS, S_CSUM, S_EMPTY
   } state_t;

   state_t             r_state, w_next;
   logic [63:0]        r_mem [DEPTH];
   logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]      r_count;
   logic [15:0]        r_ovf;
   logic [63:0]        r_hold;
   logic [2:0]         r_idx;

   logic               w_hs, w_full, w_empty, w_push, w_pop, w_load;
   logic [7:0]         w_csum;

   assign w_hs    = tx_valid & tx_ready;
   assign w_full  = (r_count == DEPTH_C);
   assign w_empty = (r_count == '0);
   // A full FIFO drops the push even if a pop completes this cycle.
   assign w_push  = rec_valid & ~flush & ~w_full;
   assign w_pop   = (r_state == S_CSUM) & w_hs & ~flush;
   assign w_load  = (r_state == S_IDLE) & read_req & ~flush & ~w_empty;

   // Record storage write port.
   // NOTE: the array is deliberately not reset; count/pointers define validity.
   always_ff @(posedge clk_adc) begin
      if (w_push) r_mem[r_wr_ptr] <= {rec_bits, rec_time};
   end

   // Pointers, count and overflow accounting; flush has priority over all.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_adc or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (rec_valid && w_full && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 1'b1;
      end
   end

   // Holding register and timestamp byte index for the frame in flight.
   always_ff @(posedge clk_adc or posedge rst) begin
      if (rst) begin
         r_hold <= '0;
         r_idx  <= '0;
      end else begin
         if (w_load) r_hold <= r_mem[r_rd_ptr];
         if (r_state == S_BITS && w_hs)     r_idx <= 3'd6;
         else if (r_state == S_TS && w_hs)  r_idx <= r_idx - 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_adc or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // FSM next-state logic; every transition out of a sending state needs a handshake.
   // NOTE: default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (read_req) w_next = w_empty ? S_EMPTY : S_HDR;
            S_HDR:   if (w_hs) w_next = S_BITS;
            S_BITS:  if (w_hs) w_next = S_TS;
            S_TS:    if (w_hs && r_idx == 3'd0) w_next = S_CSUM;
            S_CSUM:  if (w_hs) w_next = S_IDLE;
            S_EMPTY: if (w_hs) w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Checksum over the 8 payload bytes of the held record.
   always_comb begin
      w_csum = 8'h00;
      for (int i = 0; i < 8; i++) w_csum = w_csum ^ r_hold[i*8 +: 8];
   end

   // FSM outputs; data only depends on registered state, so it holds under stall.
   always_comb begin
      tx_valid = (r_state != S_IDLE);
      case (r_state)
         S_HDR:   tx_data = 8'hA5;
         S_BITS:  tx_data = r_hold[63:56];
         S_TS:    tx_data = r_hold[{r_idx, 3'b000} +: 8];
         S_CSUM:  tx_data = w_csum;
         S_EMPTY: tx_data = 8'h5A;
         default: tx_data = 8'h00;
      endcase
   end

   assign busy           = (r_state != S_IDLE);
   assign fill_level     = 5'(r_count);
   assign overflow_count = r_ovf;

endmodule

// File: doc/trig_record_readout.md
# trig_record_readout

Buffers trigger records (8-bit fired-trigger mask plus 56-bit timestamp) produced by the trigger-decision logic in a small circular FIFO. On a host read request it serialises the oldest record as a checksummed byte frame over a valid/ready byte stream toward the host transmitter. It sits between the trigger-formation block and the slow-control/serial link, replacing direct host polling of fixed 8-entry record arrays. It also provides occupancy, overflow accounting and a synchronous flush tied to the output-reset command.

## Interface
Parameters:
- DEPTH, 8: FIFO entries. Must be a power of 2, from 2 to 16.
- TS_W, 56: timestamp width. Fixed at 56; the frame format depends on it.

Ports:
- clk_adc  in  1  record/trigger clock (125 MHz domain). This is the only clock.
- rst  in  1  reset. Asynchronous, active-high.
- rec_valid  in  1  single-cycle strobe: capture one record.
- rec_bits  in  8  fired-trigger bitmask of the record.
- rec_time  in  56  timestamp of the record.
- flush  in  1  synchronous clear (level; acts on every cycle it is high).
- read_req  in  1  single-cycle host request to send one frame.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte when tx_valid and tx_ready are both high.
- fill_level  out  5  number of stored records, 0..DEPTH.
- overflow_count  out  16  number of dropped records, saturating.
- busy  out  1  a frame is in progress (state is not IDLE).

## Operation
- **Storage:** circular buffer with write pointer, read pointer and count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- **Push:** on rec_valid, if the count at the start of the cycle is less than DEPTH, write {rec_bits, rec_time} at the write pointer and advance it.
  - If the count equals DEPTH, drop the record and increment overflow_count, saturating at 0xFFFF.
  - A full FIFO drops the push even if a pop completes in the same cycle.
- **Frame format:** 10 bytes in this order:
  - 0xA5 header
  - rec_bits
  - the 7 timestamp bytes, MSB first (rec_time[55:48] … [7:0])
  - checksum: XOR of the 8 payload bytes (rec_bits and the 7 timestamp bytes; the header is excluded)
- **State machine** (IDLE, HDR, BITS, TS, CSUM, EMPTY):
  - IDLE: on read_req with count > 0, latch the head entry into a 64-bit holding register and go to HDR. On read_req with count = 0, go to EMPTY. read_req in any other state is ignored (no queuing).
  - HDR → BITS → TS: each transition happens on a handshake.
  - TS: a 3-bit byte index runs 6 down to 0 and advances on each handshake. The handshake at index 0 moves to CSUM.
  - CSUM: on handshake, pop (advance the read pointer, decrement count) and return to IDLE.
  - EMPTY: drives the single byte 0x5A. On handshake, return to IDLE.
- **Output stability:** tx_valid is high in every state except IDLE. tx_data and tx_valid must not change while tx_valid is high and tx_ready is low.
- **Push during a frame:** the record being sent comes from the holding register, so pushes during a frame do not corrupt it.
- **Flush:**
  - Pointers, count and overflow_count are cleared.
  - The FSM aborts to IDLE; tx_valid is low on the next cycle.
  - Flush takes priority over push (the record is dropped and not counted), over pop and over read_req.
- **Simultaneous push and pop** (CSUM handshake in the same cycle as a push to a non-full FIFO): both take effect and the count is unchanged.

## Timing
- **Reset values:**
  - tx_valid = 0, tx_data = 0x00, busy = 0
  - fill_level = 0, overflow_count = 0
  - FSM in IDLE, pointers 0
- **Push visibility:** a push at edge N appears in fill_level after edge N. A read_req sampled in the same cycle as the first push into an empty FIFO sees count 0 and produces the EMPTY frame.
- **Request latency:** read_req sampled at edge N → tx_valid = 1 with 0xA5 after edge N.
- **Throughput:** with tx_ready held high, the frame occupies 10 consecutive cycles, one byte per cycle. The FSM returns to IDLE after the CSUM handshake edge, and tx_valid is low for at least 1 cycle before the next frame.
- **Pop visibility:** fill_level decrements after the CSUM handshake edge.
- **Reset mid-frame:** rst asserted in any state returns all outputs to their reset values immediately (asynchronous). The partial frame is not resumed.

## Test plan
- **Reset values:** assert rst during a frame → tx_valid = 0, fill_level = 0, overflow_count = 0 immediately; after release, busy = 0.
- **Basic frame:** push bits = 0x05, time = 0x00000000001234; read_req with tx_ready = 1 → bytes A5 05 00 00 00 00 00 12 34 23 on 10 consecutive cycles; fill_level goes 1 → 0.
- **Backpressure:** same frame with tx_ready toggling 1 of every 3 cycles → identical byte sequence, tx_data stable while stalled, no byte duplicated or skipped.
- **Overflow:** push 10 records into DEPTH = 8 → fill_level = 8, overflow_count = 2. Read 8 frames → the first 8 timestamps come out in push order and fill_level = 0.
- **Empty / ignored requests:** read_req with an empty FIFO → single byte 5A, then IDLE. A second read_req during a frame is ignored (exactly one frame is sent).
- **Flush mid-frame:** 3 records stored; flush asserted during the TS byte with index 3, in the same cycle as rec_valid → tx_valid = 0 next cycle, fill_level = 0, overflow_count = 0, and the following read_req yields 5A.
